// File: rtl/wb_mem_map_n.sv
// Wishbone address decoder / response router: one master to NSLV base/mask slave windows.
// Latency: s_stb_o one clock after stb_i; ack_o one clock after the selected slave's ack (3-clock minimum per access).
// Backpressure: master holds stb_i until ack_o; stalled slaves are cut off by a watchdog that answers with err_o.
module wb_mem_map_n #(
  parameter int                   NSLV     = 2,
  parameter int                   AW       = 20,
  parameter int                   DW       = 16,
  parameter logic [NSLV*AW-1:0]   SLV_BASE = {20'h00000, 20'hB8000},
  parameter logic [NSLV*AW-1:0]   SLV_MASK = {20'h00000, 20'hFE000},
  parameter int                   TIMEOUT  = 255,
  parameter int                   TW       = 8,
  parameter logic [DW-1:0]        ERR_DATA = 16'hFFFF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [AW-1:0]      adr_i,
  input  logic [DW-1:0]      dat_i,
  output logic [DW-1:0]      dat_o,
  input  logic               we_i,
  input  logic               byte_i,
  input  logic               stb_i,
  output logic               ack_o,
  output logic               err_o,
  output logic [AW-1:0]      s_adr_o,
  output logic [DW-1:0]      s_dat_o,
  output logic               s_we_o,
  output logic               s_byte_o,
  output logic [NSLV-1:0]    s_stb_o,
  input  logic [NSLV*DW-1:0] s_dat_i,
  input  logic [NSLV-1:0]    s_ack_i
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

  state_t          state;
  logic [SW-1:0]   sel;
  logic [TW-1:0]   cnt;
  logic            any_hit;
  logic [SW-1:0]   hit_sel;
  logic [NSLV-1:0] hit_oh;

  // Request-side signals go straight to every slave; only the strobe is decoded.
  assign s_adr_o  = adr_i;
  assign s_dat_o  = dat_i;
  assign s_we_o   = we_i;
  assign s_byte_o = byte_i;

  // Window match with fixed priority: the lowest matching slave index wins.
  always_comb begin
    any_hit = 1'b0;
    hit_sel = '0;
    hit_oh  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (!any_hit &&
          (((adr_i ^ SLV_BASE[i*AW +: AW]) & SLV_MASK[i*AW +: AW]) == '0)) begin
        any_hit   = 1'b1;
        hit_sel   = SW'(i);
        hit_oh[i] = 1'b1;
      end
    end
  end

  // Transaction FSM; all master- and slave-facing outputs are registered here.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      sel     <= '0;
      cnt     <= '0;
      dat_o   <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      s_stb_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_o <= 1'b0;
          err_o <= 1'b0;
          if (stb_i) begin
            if (any_hit) begin
              sel     <= hit_sel;
              s_stb_o <= hit_oh;
              cnt     <= '0;
              state   <= BUSY;
            end else begin
              // Unmapped address: answer immediately with an error beat.
              ack_o <= 1'b1;
              err_o <= 1'b1;
              dat_o <= ERR_DATA;
              state <= ERR;
            end
          end
        end
        BUSY: begin
          if (!stb_i) begin
            // Master gave up: withdraw the slave strobe silently.
            s_stb_o <= '0;
            state   <= IDLE;
          end else if (s_ack_i[sel]) begin
            dat_o   <= s_dat_i[sel*DW +: DW];
            s_stb_o <= '0;
            ack_o   <= 1'b1;
            state   <= RESP;
          end else if (cnt == TW'(TIMEOUT - 1)) begin
            // Watchdog expired; any later ack from this slave lands in IDLE and is ignored.
            s_stb_o <= '0;
            ack_o   <= 1'b1;
            err_o   <= 1'b1;
            dat_o   <= ERR_DATA;
            state   <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP, ERR: begin
          ack_o <= 1'b0;
          err_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_map_n.sv
// Directed bench for wb_mem_map_n: default map instance plus a TIMEOUT=4 instance with a narrow slave1 window.
// Cycle n is the interval after the n-th rising edge following request setup; checks sample 1ns after the edge.
// Slave responses are driven by the bench (manual ack masks or an auto zero-wait responder).
module tb_wb_mem_map_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] adr;
  logic [15:0] wdat;
  logic        we, byt, stb;

  logic [15:0] rdat, rdat2;
  logic        ack, err, ack2, err2;
  logic [19:0] s_adr, s_adr2;
  logic [15:0] s_dat, s_dat2;
  logic        s_we, s_we2, s_byte, s_byte2;
  logic [1:0]  s_stb, s_stb2;
  logic [31:0] s_rdat;
  logic [1:0]  ack_man, ack2_man, s_ack, s_ack2;
  logic        auto_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Bench slave: manual ack mask, optionally ORed with a zero-wait responder.
  assign s_ack  = ack_man | (auto_ack ? s_stb : 2'b00);
  assign s_ack2 = ack2_man;

  wb_mem_map_n u_dut (
    .clk_i(clk), .rst_i(rst_n), .adr_i(adr), .dat_i(wdat), .dat_o(rdat),
    .we_i(we), .byte_i(byt), .stb_i(stb), .ack_o(ack), .err_o(err),
    .s_adr_o(s_adr), .s_dat_o(s_dat), .s_we_o(s_we), .s_byte_o(s_byte),
    .s_stb_o(s_stb), .s_dat_i(s_rdat), .s_ack_i(s_ack)
  );

  wb_mem_map_n #(
    .SLV_BASE({20'h10000, 20'hB8000}),
    .SLV_MASK({20'hF0000, 20'hFE000}),
    .TIMEOUT (4)
  ) u_dut2 (
    .clk_i(clk), .rst_i(rst_n), .adr_i(adr), .dat_i(wdat), .dat_o(rdat2),
    .we_i(we), .byte_i(byt), .stb_i(stb), .ack_o(ack2), .err_o(err2),
    .s_adr_o(s_adr2), .s_dat_o(s_dat2), .s_we_o(s_we2), .s_byte_o(s_byte2),
    .s_stb_o(s_stb2), .s_dat_i(s_rdat), .s_ack_i(s_ack2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the setup point of cycle 0 with both DUTs idle.
  task automatic do_reset();
    rst_n    = 1'b0;
    stb      = 1'b0;
    we       = 1'b0;
    ack_man  = 2'b00;
    ack2_man = 2'b00;
    auto_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [19:0] alist [3];
  logic [15:0] dlist [3];
  int          acyc  [3];
  logic [15:0] adat  [3];
  logic        seen, errv;
  logic [15:0] datv;
  int          hi, ack_cyc, extra, nack;

  initial begin
    rst_n = 1'b1; adr = '0; wdat = '0; we = 1'b0; byt = 1'b0; stb = 1'b0;
    s_rdat = '0; ack_man = '0; ack2_man = '0; auto_ack = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dat", rdat, 16'h0000);
    chk("rst_ack", ack, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_stb", s_stb, 2'b00);

    // Read from the VDU window, slave0 acks one cycle after its strobe.
    do_reset();
    adr = 20'hB8010; stb = 1'b1; s_rdat = {16'h0000, 16'h0741};
    tick();
    chk("t1_stb_c1", s_stb, 2'b01);
    seen = s_stb[1];
    tick();
    chk("t1_ack_c2", ack, 1'b0);
    seen |= s_stb[1];
    ack_man = 2'b01;
    tick();
    chk("t1_ack_c3", ack, 1'b1);
    chk("t1_dat_c3", rdat, 16'h0741);
    chk("t1_err_c3", err, 1'b0);
    chk("t1_stb_c3", s_stb, 2'b00);
    seen |= s_stb[1];
    stb = 1'b0; ack_man = 2'b00;
    tick();
    chk("t1_ack_c4", ack, 1'b0);
    chk("t1_s1_never", seen, 1'b0);

    // Write to the catch-all slave1 with a zero-wait ack.
    do_reset();
    adr = 20'h00400; wdat = 16'hA55A; we = 1'b1; byt = 1'b1; stb = 1'b1;
    #1;
    chk("t2_sdat", s_dat, 16'hA55A);
    chk("t2_swe", s_we, 1'b1);
    chk("t2_sadr", s_adr, 20'h00400);
    chk("t2_sbyte", s_byte, 1'b1);
    tick();
    chk("t2_stb_c1", s_stb, 2'b10);
    ack_man = 2'b10;
    tick();
    chk("t2_ack_c2", ack, 1'b1);
    chk("t2_err_c2", err, 1'b0);
    stb = 1'b0; we = 1'b0; byt = 1'b0; ack_man = 2'b00;

    // Unmapped address on the narrow map answers with an error beat.
    do_reset();
    adr = 20'h20000; stb = 1'b1;
    tick();
    chk("t3_ack_c1", ack2, 1'b1);
    chk("t3_err_c1", err2, 1'b1);
    chk("t3_dat_c1", rdat2, 16'hFFFF);
    chk("t3_stb_c1", s_stb2, 2'b00);
    stb = 1'b0;
    tick();
    chk("t3_ack_c2", ack2, 1'b0);

    // Silent slave0 on the TIMEOUT=4 instance, then a late ack that must be ignored.
    do_reset();
    adr = 20'hB8000; stb = 1'b1;
    hi = 0; ack_cyc = 0; extra = 0; errv = 1'b0; datv = '0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (s_stb2[0]) hi++;
      if (ack2) begin
        if (ack_cyc == 0) begin
          ack_cyc = c; errv = err2; datv = rdat2;
          stb = 1'b0; ack2_man = 2'b01;
        end else begin
          extra++;
        end
      end
    end
    chk("t4_stb_cycles", hi, 4);
    chk("t4_ack_cycle", ack_cyc, 5);
    chk("t4_err", errv, 1'b1);
    chk("t4_dat", datv, 16'hFFFF);
    chk("t4_late_ack", extra, 0);
    ack2_man = 2'b00;

    // Back-to-back zero-wait reads with stb held high.
    do_reset();
    alist[0] = 20'hB8000; alist[1] = 20'h00000; alist[2] = 20'hB8002;
    dlist[0] = 16'h1111;  dlist[1] = 16'h2222;  dlist[2] = 16'h1111;
    s_rdat = {16'h2222, 16'h1111};
    auto_ack = 1'b1; adr = alist[0]; stb = 1'b1; nack = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (ack) begin
        if (nack < 3) begin
          acyc[nack] = c; adat[nack] = rdat;
        end
        nack++;
        if (nack < 3) adr = alist[nack];
        else stb = 1'b0;
      end
    end
    chk("t5_nack", nack, 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t5_cyc%0d", k), acyc[k], 2 + 3 * k);
      chk($sformatf("t5_dat%0d", k), adat[k], dlist[k]);
    end
    auto_ack = 1'b0;

    // Master abort in BUSY, then a fresh request proves the FSM is idle.
    do_reset();
    adr = 20'hB8000; stb = 1'b1;
    tick();
    chk("t6a_stb_c1", s_stb, 2'b01);
    stb = 1'b0;
    tick();
    chk("t6a_stb_c2", s_stb, 2'b00);
    chk("t6a_ack_c2", ack, 1'b0);
    adr = 20'h00000; stb = 1'b1;
    tick();
    chk("t6a_restart", s_stb, 2'b10);
    stb = 1'b0;
    tick();
    chk("t6a_noack", ack, 1'b0);

    // Asynchronous reset in BUSY clears the strobe without waiting for a clock.
    do_reset();
    adr = 20'hB8000; stb = 1'b1;
    tick();
    chk("t6b_stb_c1", s_stb, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("t6b_stb_async", s_stb, 2'b00);
    chk("t6b_ack_async", ack, 1'b0);
    stb = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_rdat = {16'h3333, 16'h4444};
    adr = 20'h00000; stb = 1'b1; auto_ack = 1'b1;
    tick();
    chk("t6b_restart", s_stb, 2'b10);
    tick();
    chk("t6b_ack", ack, 1'b1);
    chk("t6b_dat", rdat, 16'h3333);
    stb = 1'b0; auto_ack = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
